// File: rtl/systolic_ctrl_pkg.sv
// Shared types and CSR layout for the systolic array sequencer.
// State encoding, Avalon word addresses and CTRL/STATUS bit positions.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_SIZE   = 2'd2;
    localparam logic [1:0] CSR_CYCLES = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_ABORT   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

endpackage

// File: rtl/systolic_ctrl_csr.sv
// Avalon-MM register file: start/abort pulses, irq_en, clamped size, sticky done/aborted.
// Read data is registered (latency 1); the slave never stalls, so there is no backpressure.
module systolic_ctrl_csr
    import systolic_ctrl_pkg::*;
#(
    parameter int N   = 8,
    parameter int K_W = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     avs_address,
    input  logic           avs_read,
    input  logic           avs_write,
    input  logic [31:0]    avs_writedata,
    output logic [31:0]    avs_readdata,
    input  logic           busy,
    input  logic           done_set,
    input  logic [31:0]    cycles,
    output logic           start,
    output logic           abort,
    output logic           irq_en,
    output logic           done,
    output logic           aborted,
    output logic [K_W-1:0] size
);

    logic           irq_en_q, done_q, aborted_q;
    logic [K_W-1:0] size_q, size_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           wr_ctrl, wr_status, wr_size;
    logic           unused_wd;

    assign unused_wd = &{1'b0, avs_writedata[31:K_W]};

    assign wr_ctrl   = avs_write && (avs_address == CSR_CTRL);
    assign wr_status = avs_write && (avs_address == CSR_STATUS);
    assign wr_size   = avs_write && (avs_address == CSR_SIZE) && !busy;

    // Abort dominates start; both are pre-qualified by busy so the FSM can use them directly.
    assign abort = wr_ctrl && avs_writedata[CTRL_ABORT] && busy;
    assign start = wr_ctrl && avs_writedata[CTRL_START] && !avs_writedata[CTRL_ABORT] && !busy;

    always_comb begin
        size_d = avs_writedata[K_W-1:0];
        if (size_d == '0)
            size_d = K_W'(1);
        else if (size_d > K_W'(N))
            size_d = K_W'(N);
    end

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            CSR_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
            CSR_STATUS: begin
                rdata_d[STAT_BUSY]    = busy;
                rdata_d[STAT_DONE]    = done_q;
                rdata_d[STAT_ABORTED] = aborted_q;
            end
            CSR_SIZE:   rdata_d[K_W-1:0] = size_q;
            default:    rdata_d = cycles;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            size_q    <= K_W'(N);
            rdata_q   <= '0;
        end else begin
            if (wr_ctrl)
                irq_en_q <= avs_writedata[CTRL_IRQ_EN];
            if (wr_size)
                size_q <= size_d;
            if (done_set)
                done_q <= 1'b1;
            else if (start || (wr_status && avs_writedata[STAT_DONE]))
                done_q <= 1'b0;
            if (abort)
                aborted_q <= 1'b1;
            else if (wr_status && avs_writedata[STAT_ABORTED])
                aborted_q <= 1'b0;
            rdata_q <= avs_read ? rdata_d : '0;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq_en       = irq_en_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign size         = size_q;

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequences an NxN output-stationary array: clear, skewed feed (3k-2), drain (k), done; 4k cycles per run.
// Array strobes are registered; the array is assumed always ready, so no backpressure is applied.
module systolic_array_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = $clog2(3 * N - 2),
    parameter int K_W    = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic              array_clr,
    output logic              array_en,
    output logic [STEP_W-1:0] feed_step,
    output logic [K_W-1:0]    feed_k,
    output logic              drain_en,
    output logic [K_W-1:0]    drain_row,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d, last_step;
    logic [K_W-1:0]    row_q, row_d, k_q, size;
    logic [31:0]       cycles_q;
    logic              clr_q, en_q, drain_q, busy_q;
    logic              start, abort, irq_en, done, aborted, done_set;
    logic              unused_aborted;

    assign unused_aborted = aborted;

    systolic_ctrl_csr #(.N(N), .K_W(K_W)) u_csr (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .busy          (busy_q),
        .done_set      (done_set),
        .cycles        (cycles_q),
        .start         (start),
        .abort         (abort),
        .irq_en        (irq_en),
        .done          (done),
        .aborted       (aborted),
        .size          (size)
    );

    assign last_step = STEP_W'(3 * int'(k_q) - 3);
    assign done_set  = (state_q == DONE) && !abort;

    always_comb begin
        state_d = state_q;
        step_d  = '0;
        row_d   = '0;
        case (state_q)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: state_d = FEED;
            FEED: begin
                if (step_q == last_step)
                    state_d = DRAIN;
                else
                    step_d = step_q + STEP_W'(1);
            end
            DRAIN: begin
                if (row_q == k_q - K_W'(1))
                    state_d = DONE;
                else
                    row_d = row_q + K_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            step_d  = '0;
            row_d   = '0;
        end
    end

    // Strobes are decoded from the next state so they line up with state_q and leave a flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            row_q    <= '0;
            k_q      <= '0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            row_q   <= row_d;
            clr_q   <= (state_d == CLEAR);
            en_q    <= (state_d == FEED);
            drain_q <= (state_d == DRAIN);
            busy_q  <= (state_d != IDLE);
            if (start)
                k_q <= size;
            if (start)
                cycles_q <= '0;
            else if (state_q != IDLE)
                cycles_q <= cycles_q + 32'd1;
        end
    end

    assign irq       = done & irq_en;
    assign array_clr = clr_q;
    assign array_en  = en_q;
    assign feed_step = step_q;
    assign feed_k    = k_q;
    assign drain_en  = drain_q;
    assign drain_row = row_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed + randomized bench for systolic_array_ctrl with a phase-arithmetic reference model.
module tb_systolic_array_ctrl;

    localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_SIZE = 2'd2, A_CYCLES = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq, array_clr, array_en, drain_en, busy;
    logic [4:0]  feed_step;
    logic [3:0]  feed_k, drain_row;

    int vectors = 0;
    int miscompares = 0;

    bit m_irq_en, m_done, m_aborted;
    int m_size;

    systolic_array_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .array_clr     (array_clr),
        .array_en      (array_en),
        .feed_step     (feed_step),
        .feed_k        (feed_k),
        .drain_en      (drain_en),
        .drain_row     (drain_row),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        check(tag, avs_readdata, exp);
    endtask

    function automatic int clamp(input int v);
        if (v == 0) return 1;
        if (v > 8) return 8;
        return v;
    endfunction

    function automatic logic [31:0] exp_status();
        return {29'b0, m_aborted, m_done, 1'b0};
    endfunction

    // Offset j counts cycles after the start write: 0 clear, 1..3k-2 feed, then k drain rows, then done.
    task automatic chk_cycle(input int k, input int j);
        int clr, en, step, dr, row, e;
        logic [31:0] obs;
        clr  = (j == 0) ? 1 : 0;
        en   = (j >= 1 && j <= 3 * k - 2) ? 1 : 0;
        step = en ? j - 1 : 0;
        dr   = (j >= 3 * k - 1 && j <= 4 * k - 2) ? 1 : 0;
        row  = dr ? j - (3 * k - 1) : 0;
        e = (int'(m_done & m_irq_en) << 17) | (1 << 16) | (clr << 15) | (en << 14)
          | (step << 9) | (dr << 8) | (row << 4) | k;
        obs = {14'b0, irq, busy, array_clr, array_en, (array_en ? feed_step : 5'd0),
               drain_en, (drain_en ? drain_row : 4'd0), feed_k};
        check($sformatf("trace k=%0d j=%0d", k, j), obs, e);
    endtask

    task automatic chk_idle(input string tag);
        check(tag, {27'b0, irq, busy, array_clr, array_en, drain_en},
              {27'b0, m_done & m_irq_en, 4'b0});
    endtask

    task automatic run_and_check(input int k);
        for (int j = 0; j < 4 * k; j++) begin
            chk_cycle(k, j);
            tick();
        end
        m_done = 1'b1;
        chk_idle($sformatf("post_run k=%0d", k));
        rd_chk(A_STATUS, exp_status(), "status_after_run");
        rd_chk(A_CYCLES, 32'(4 * k), "cycles_after_run");
        rd_chk(A_CTRL, {30'b0, m_irq_en, 1'b0}, "ctrl_after_run");
    endtask

    task automatic full_run(input int v, input bit ie);
        wr(A_SIZE, 32'(v));
        m_size = clamp(v);
        rd_chk(A_SIZE, 32'(m_size), $sformatf("size_clamp v=%0d", v));
        wr(A_CTRL, {30'b0, ie, 1'b1});
        m_irq_en = ie;
        m_done   = 1'b0;
        run_and_check(m_size);
    endtask

    initial begin
        int a, r, k;
        m_irq_en = 0; m_done = 0; m_aborted = 0; m_size = 8;

        // Reset state.
        tick();
        tick();
        check("reset_outputs", {14'b0, irq, busy, array_clr, array_en, feed_step, drain_en, drain_row, feed_k}, 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        tick();
        rd_chk(A_CTRL, 32'd0, "rst_ctrl");
        rd_chk(A_STATUS, 32'd0, "rst_status");
        rd_chk(A_SIZE, 32'd8, "rst_size");
        rd_chk(A_CYCLES, 32'd0, "rst_cycles");

        // Directed runs: k=4 with irq, k=1 edge, clamp high.
        full_run(4, 1'b1);
        wr(A_STATUS, 32'd2);
        m_done = 1'b0;
        chk_idle("w1c_done_idle");
        full_run(0, 1'b0);
        full_run(15, 1'b1);

        // Randomized runs.
        for (int i = 0; i < 6; i++) begin
            full_run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                wr(A_STATUS, 32'd2);
                m_done = 1'b0;
                rd_chk(A_STATUS, exp_status(), "w1c_done_rand");
            end
        end

        // Mid-feed size write, restart attempt, then abort.
        wr(A_SIZE, 32'd8);
        m_size = 8;
        wr(A_CTRL, 32'd1);
        m_irq_en = 0; m_done = 0;
        a = int'($urandom_range(1, 18));
        for (int j = 0; j < a; j++) begin
            chk_cycle(8, j);
            tick();
        end
        chk_cycle(8, a);
        wr(A_SIZE, 32'd2);
        chk_cycle(8, a + 1);
        wr(A_CTRL, 32'd1);
        chk_cycle(8, a + 2);
        wr(A_CTRL, 32'd4);
        m_aborted = 1'b1;
        chk_idle("abort_idle");
        rd_chk(A_SIZE, 32'd8, "size_busy_ignored");
        rd_chk(A_STATUS, 32'd4, "status_aborted");
        rd_chk(A_CYCLES, 32'(a + 3), "cycles_frozen");
        wr(A_STATUS, 32'd4);
        m_aborted = 1'b0;
        rd_chk(A_STATUS, 32'd0, "w1c_aborted");
        wr(A_CTRL, 32'd4);
        rd_chk(A_STATUS, 32'd0, "abort_in_idle");

        // W1C of done on the DONE cycle loses to the set; irq_en masks irq.
        k = int'($urandom_range(2, 8));
        wr(A_SIZE, 32'(k));
        wr(A_CTRL, 32'd3);
        m_irq_en = 1; m_done = 0;
        for (int j = 0; j < 4 * k - 1; j++) begin
            chk_cycle(k, j);
            tick();
        end
        chk_cycle(k, 4 * k - 1);
        wr(A_STATUS, 32'd2);
        m_done = 1'b1;
        chk_idle("done_set_wins");
        rd_chk(A_STATUS, 32'd2, "status_done_kept");
        wr(A_CTRL, 32'd0);
        m_irq_en = 0;
        chk_idle("irq_masked");
        rd_chk(A_STATUS, 32'd2, "done_survives_mask");
        wr(A_CTRL, 32'd2);
        m_irq_en = 1;
        chk_idle("irq_unmasked");
        wr(A_STATUS, 32'd2);
        m_done = 1'b0;
        chk_idle("irq_after_w1c");
        rd_chk(A_STATUS, 32'd0, "status_cleared");

        // Reset during DRAIN, then a fresh run at the reset size.
        wr(A_SIZE, 32'd8);
        wr(A_CTRL, 32'd3);
        m_irq_en = 1; m_done = 0;
        r = int'($urandom_range(0, 7));
        for (int j = 0; j < 23 + r; j++) begin
            chk_cycle(8, j);
            tick();
        end
        reset_n = 1'b0;
        tick();
        check("midrun_reset_outputs", {14'b0, irq, busy, array_clr, array_en, feed_step, drain_en, drain_row, feed_k}, 32'd0);
        check("midrun_reset_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        m_irq_en = 0; m_done = 0; m_aborted = 0; m_size = 8;
        rd_chk(A_CTRL, 32'd0, "rst2_ctrl");
        rd_chk(A_STATUS, 32'd0, "rst2_status");
        rd_chk(A_SIZE, 32'd8, "rst2_size");
        rd_chk(A_CYCLES, 32'd0, "rst2_cycles");
        wr(A_CTRL, 32'd1);
        run_and_check(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
